// File: rtl/reg_file.sv
// reg_file: RV32 integer register file, 32 x 32 bits.
// Two combinational read ports and one synchronous write port.
// Register x0 is hardwired to zero.
//
// Ports:
//   clk    - system clock; all state changes on the rising edge
//   rst    - synchronous, active-high reset; clears x1..x31 and drops a write in the same cycle
//   RegWEn - write enable for the write port
//   rs1    - read address, port 1
//   rs2    - read address, port 2
//   rsW    - write address; a write to x0 is ignored
//   dataW  - write data
//   data1  - read data for rs1; 0 when rs1 is 0
//   data2  - read data for rs2; 0 when rs2 is 0
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWEn,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rsW,
  input  logic [DATA_WIDTH-1:0] dataW,
  output logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] data2
);

  // Only x1..x(NUM_REGS-1) hold state; x0 has no storage.
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

  // Reset has priority over the write; a write to x0 matches no entry.
  always_ff @(posedge clk) begin
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (rst) begin
        regs[i] <= '0;
      end else if (RegWEn && (rsW == ADDR_WIDTH'(i))) begin
        regs[i] <= dataW;
      end
    end
  end

  // Unbypassed combinational reads; x0 forced to zero so no X escapes before reset.
  always_comb begin
    data1 = '0;
    data2 = '0;
    if (rs1 != '0) data1 = regs[rs1];
    if (rs2 != '0) data2 = regs[rs2];
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file.
// Expected read values are queued when the read addresses are driven and
// popped against data1/data2 once the combinational outputs have settled.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        RegWEn;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rsW;
  logic [31:0] dataW;
  logic [31:0] data1;
  logic [31:0] data2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  string       tag_q [$];
  logic [31:0] exp_q [$];

  // Reference contents for randomized traffic (index 0 unused).
  logic [31:0] model [32];

  reg_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS  (32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .RegWEn(RegWEn),
    .rs1   (rs1),
    .rs2   (rs2),
    .rsW   (rsW),
    .dataW (dataW),
    .data1 (data1),
    .data2 (data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pop the two pending expectations and compare against both read ports.
  task automatic drain_pair();
    if (tag_q.size() < 2 || exp_q.size() < 2) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got %0d entries expected 2", exp_q.size());
    end else begin
      check(tag_q.pop_front(), data1, exp_q.pop_front());
      check(tag_q.pop_front(), data2, exp_q.pop_front());
    end
  endtask

  // One clock edge with the given write-port inputs; model tracks the effect.
  task automatic do_cycle(input logic r, input logic en, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rst    = r;
    RegWEn = en;
    rsW    = a;
    dataW  = d;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (en && a != 5'd0) begin
      model[a] = d;
    end
    #1;
    rst    = 1'b0;
    RegWEn = 1'b0;
  endtask

  // Read both ports with explicitly given expectations.
  task automatic exp_pair(input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] e1, input logic [31:0] e2, input string tag);
    @(negedge clk);
    rs1 = a;
    rs2 = b;
    tag_q.push_back($sformatf("%s.d1[x%0d]", tag, a));
    exp_q.push_back(e1);
    tag_q.push_back($sformatf("%s.d2[x%0d]", tag, b));
    exp_q.push_back(e2);
    #1;
    drain_pair();
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  initial begin
    rst = 1'b0; RegWEn = 1'b0; rs1 = '0; rs2 = '0; rsW = '0; dataW = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // x0 reads zero even before any reset.
    #1;
    tag_q.push_back("pre_reset.d1"); exp_q.push_back(32'h0);
    tag_q.push_back("pre_reset.d2"); exp_q.push_back(32'h0);
    drain_pair();

    // Reset state.
    do_cycle(1'b1, 1'b0, 5'd0, 32'h0);
    exp_pair(5'd1, 5'd31, 32'h0, 32'h0, "reset");
    exp_pair(5'd16, 5'd0, 32'h0, 32'h0, "reset");

    // Basic write/read.
    do_cycle(1'b0, 1'b1, 5'd3, 32'd55);
    exp_pair(5'd3, 5'd0, 32'd55, 32'h0, "basic");

    // x0 immutability.
    do_cycle(1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
    exp_pair(5'd0, 5'd0, 32'h0, 32'h0, "x0");

    // Write enable gating.
    do_cycle(1'b0, 1'b1, 5'd5, 32'h12345678);
    do_cycle(1'b0, 1'b0, 5'd5, 32'hFFFFFFFF);
    exp_pair(5'd5, 5'd5, 32'h12345678, 32'h12345678, "wen");

    // Reset clears and beats a concurrent write.
    do_cycle(1'b0, 1'b1, 5'd1, 32'd7);
    do_cycle(1'b0, 1'b1, 5'd31, 32'd9);
    exp_pair(5'd1, 5'd31, 32'd7, 32'd9, "pre_rst");
    do_cycle(1'b1, 1'b1, 5'd2, 32'd100);
    exp_pair(5'd1, 5'd31, 32'h0, 32'h0, "rst_clr");
    exp_pair(5'd2, 5'd3, 32'h0, 32'h0, "rst_drop");

    // Full sweep and dual-port pairs.
    for (int i = 1; i < 32; i++) do_cycle(1'b0, 1'b1, 5'(i), 32'(i * 3 + 1));
    for (int i = 0; i < 32; i++) begin
      exp_pair(5'(i), 5'(31 - i),
               (i == 0)  ? 32'h0 : 32'(i * 3 + 1),
               (i == 31) ? 32'h0 : 32'((31 - i) * 3 + 1), "sweep");
    end

    // Read-during-write: old value before the edge, new value right after.
    do_cycle(1'b0, 1'b1, 5'd4, 32'd10);
    @(negedge clk);
    rs1 = 5'd4; rs2 = 5'd4;
    RegWEn = 1'b1; rsW = 5'd4; dataW = 32'd20;
    tag_q.push_back("rdw_before.d1"); exp_q.push_back(32'd10);
    tag_q.push_back("rdw_before.d2"); exp_q.push_back(32'd10);
    #1;
    drain_pair();
    @(posedge clk);
    model[4] = 32'd20;
    tag_q.push_back("rdw_after.d1"); exp_q.push_back(32'd20);
    tag_q.push_back("rdw_after.d2"); exp_q.push_back(32'd20);
    #1;
    drain_pair();
    RegWEn = 1'b0;

    // Randomized writes and reads against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [4:0] wa, ra, rb;
      wa = 5'($urandom_range(0, 31));
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      do_cycle(1'b0, 1'($urandom_range(0, 1)), wa, $urandom);
      exp_pair(ra, rb, model_rd(ra), model_rd(rb), "rand");
    end

    // Reset mid-operation, then normal writes resume.
    do_cycle(1'b1, 1'b0, 5'd0, 32'h0);
    exp_pair(5'd4, 5'd5, 32'h0, 32'h0, "mid_rst");
    do_cycle(1'b0, 1'b1, 5'd6, 32'hA5A5A5A5);
    exp_pair(5'd6, 5'd7, 32'hA5A5A5A5, 32'h0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry by 32-bit integer register file for the RV32 processor core.
- Provides two combinational read ports (rs1/rs2 operands) and one synchronous write port (writeback stage).
- Register x0 is hardwired to zero, per the RISC-V ISA.
- Sits between the decode stage (read addresses) and the writeback stage (write address, data, enable).

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register address ports.
- NUM_REGS, 32, number of architectural registers; equals 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- RegWEn  input  1  write enable for the write port.
- rs1  input  ADDR_WIDTH  read address, port 1.
- rs2  input  ADDR_WIDTH  read address, port 2.
- rsW  input  ADDR_WIDTH  write address.
- dataW  input  DATA_WIDTH  write data.
- data1  output  DATA_WIDTH  read data for rs1.
- data2  output  DATA_WIDTH  read data for rs2.

Interface note: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Storage: NUM_REGS registers of DATA_WIDTH bits. Index 0 holds no writable state.
- Reset:
  - On a rising clk edge with rst=1, all registers x1..x31 clear to 0.
  - rst has priority over any write in the same cycle; that write is dropped.
  - After the reset edge, data1 and data2 read 0 for every address.
- Write:
  - On a rising clk edge with rst=0 and RegWEn=1, register[rsW] takes dataW.
  - When rsW=0 the write is silently ignored; x0 stays 0.
  - RegWEn=0 leaves all registers unchanged.
- Read:
  - Purely combinational, zero-cycle latency.
  - data1 = (rs1==0) ? 0 : register[rs1]; data2 likewise for rs2.
  - Outputs follow address changes within the same cycle, with no clock needed.
- Read during write:
  - There is no internal bypass. Before the write edge, a read of rsW returns the old value.
  - Immediately after the edge, the read returns the new value through the combinational path.
  - Forwarding is the pipeline's responsibility.
- Simultaneous reads: rs1 and rs2 may address the same register; both ports return the same value.
- Before the first reset, register contents are undefined. The x0 read is always 0 regardless of reset.
- Reset mid-operation: a reset edge between writes discards all prior writes; subsequent writes behave normally.
- No X propagation from x0 under any input.

Test Plan:
- Basic write/read:
  - Reset, then write 55 to x3 (RegWEn=1, rsW=3, dataW=55) for one edge.
  - Drop RegWEn and set rs1=3, rs2=0.
  - Required: data1=55, data2=0.
- x0 immutability:
  - Write 0xDEADBEEF to rsW=0.
  - Required: reading rs1=0 and rs2=0 gives data1=0, data2=0.
- Write enable gating:
  - Write 0x12345678 to x5, then present rsW=5, dataW=0xFFFFFFFF with RegWEn=0 for one edge.
  - Required: reading x5 gives 0x12345678.
- Reset clears:
  - Write 7 to x1 and 9 to x31, then assert rst for one edge while RegWEn=1, rsW=2, dataW=100.
  - Required: x1, x31 and x2 all read 0.
- Dual-port and full sweep:
  - Write value i*3+1 to every xi, i=1..31.
  - Read all pairs (rs1=i, rs2=31-i).
  - Required: data1=i*3+1, data2=(31-i)*3+1, and 0 wherever the address is 0.
- Read-during-write timing:
  - Hold rs1=4 with x4=10, then write 20 to x4.
  - Required: data1=10 before the edge and 20 immediately after the edge.
